// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: memory-op codes, response
// error codes and the FSM state type.
package lsu_pkg;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEM  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, store byte-mask/replication
// and load extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  memop_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        legal_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // NOTE: every output gets a default before the case so no latch is inferred
  // for op codes that leave some outputs unassigned.
  always_comb begin
    legal_o = 1'b0;
    wmask_o = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    shifted = rdata_i >> {off_i, 3'b000};
    case (memop_i)
      MOP_B, MOP_BU: begin
        legal_o = 1'b1;
        wmask_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (memop_i == MOP_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'b0, shifted[7:0]};
      end
      MOP_H, MOP_HU: begin
        legal_o = ~off_i[0];
        wmask_o = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = (memop_i == MOP_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'b0, shifted[15:0]};
      end
      MOP_W: begin
        legal_o = (off_i == 2'b00);
        wmask_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one ALU-addressed request, runs a single req/ack
// memory transaction with timeout, and returns a one-cycle response pulse.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] CNT_LAST = 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  memop_q;
  logic [1:0]  off_q;

  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;

  logic        idle;
  logic        accept;
  logic [2:0]  al_memop;
  logic [1:0]  al_off;
  logic        al_legal;
  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle & req_valid;

  // In IDLE the checker looks at the incoming request; in MEM it extracts
  // load data using the latched op and byte offset.
  assign al_memop = idle ? req_memop : memop_q;
  assign al_off   = idle ? req_addr[1:0] : off_q;

  lsu_align u_align (
    .memop_i (al_memop),
    .off_i   (al_off),
    .wdata_i (req_wdata),
    .rdata_i (mem_rdata),
    .legal_o (al_legal),
    .wmask_o (al_wmask),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (!al_legal) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ALIGN;
          end else begin
            state_d     = ST_MEM;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wmask_d = req_we ? al_wmask : 4'b0000;
            mem_wdata_d = req_we ? al_wdata : '0;
          end
        end
      end
      ST_MEM: begin
        // An ack in the final timeout cycle still completes normally.
        if (mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : al_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      memop_q     <= MOP_B;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= 4'b0000;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        memop_q <= req_memop;
        off_q   <= req_addr[1:0];
      end
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, signed/unsigned loads, alignment errors,
// timeout, late ack and asynchronous reset mid-transaction.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_memop = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  lsu #(.MEM_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_memop (req_memop),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_memop = op;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
  endtask

  int hi_cycles;

  initial begin
    // Reset values
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    step();

    // Ack outside MEM is ignored
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("idle_ack_rsp", 32'(rsp_valid), 32'd0);
    check("idle_ack_req", 32'(mem_req), 32'd0);

    // Store byte at offset 3, ack in first MEM cycle
    issue(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CC5A);
    check("sb_mem_req", 32'(mem_req), 32'd1);
    check("sb_mem_we", 32'(mem_we), 32'd1);
    check("sb_mem_addr", mem_addr, 32'h0000_1000);
    check("sb_wmask", 32'(mem_wmask), 32'b1000);
    check("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
    check("sb_ready_busy", 32'(req_ready), 32'd0);
    check("sb_no_rsp_yet", 32'(rsp_valid), 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sb_rsp_valid", 32'(rsp_valid), 32'd1);
    check("sb_rsp_err", 32'(rsp_err), 32'd0);
    check("sb_rsp_rdata", rsp_rdata, 32'h0);
    check("sb_mem_req_drop", 32'(mem_req), 32'd0);
    step();
    check("sb_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("sb_ready_back", 32'(req_ready), 32'd1);

    // Store half at offset 2
    issue(1'b1, 3'b001, 32'h0000_5002, 32'h1234_ABCD);
    check("sh_wmask", 32'(mem_wmask), 32'b1100);
    check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    check("sh_mem_addr", mem_addr, 32'h0000_5000);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("sh_rsp_err", 32'(rsp_err), 32'd0);
    step();

    // Signed half load at offset 2
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h0);
    check("lh_mem_we", 32'(mem_we), 32'd0);
    check("lh_wmask", 32'(mem_wmask), 32'd0);
    check("lh_mem_addr", mem_addr, 32'h0000_2000);
    mem_ack = 1'b1;
    mem_rdata = 32'h80F0_1234;
    step();
    mem_ack = 1'b0;
    check("lh_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lh_rdata", rsp_rdata, 32'hFFFF_80F0);
    step();

    // Unsigned half load at offset 2
    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("lhu_rdata", rsp_rdata, 32'h0000_80F0);
    step();

    // Signed byte load at offset 1
    issue(1'b0, 3'b000, 32'h0000_2001, 32'h0);
    mem_ack = 1'b1;
    mem_rdata = 32'h0000_9A00;
    step();
    mem_ack = 1'b0;
    check("lb_rdata", rsp_rdata, 32'hFFFF_FF9A);
    step();

    // Misaligned word load: error next cycle, memory untouched
    issue(1'b0, 3'b010, 32'h0000_3001, 32'h0);
    check("mw_mem_req", 32'(mem_req), 32'd0);
    check("mw_rsp_valid", 32'(rsp_valid), 32'd1);
    check("mw_rsp_err", 32'(rsp_err), 32'd1);
    check("mw_rsp_rdata", rsp_rdata, 32'h0);
    step();
    check("mw_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("mw_mem_req_after", 32'(mem_req), 32'd0);
    check("mw_ready", 32'(req_ready), 32'd1);

    // Illegal memop at aligned address
    issue(1'b0, 3'b011, 32'h0000_3000, 32'h0);
    check("il_mem_req", 32'(mem_req), 32'd0);
    check("il_rsp_valid", 32'(rsp_valid), 32'd1);
    check("il_rsp_err", 32'(rsp_err), 32'd1);
    step();

    // Misaligned half store
    issue(1'b1, 3'b101, 32'h0000_5001, 32'hFFFF_FFFF);
    check("mh_mem_req", 32'(mem_req), 32'd0);
    check("mh_rsp_err", 32'(rsp_err), 32'd1);
    step();

    // Timeout: no ack, mem_req high exactly 4 cycles
    issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    hi_cycles = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      hi_cycles++;
      step();
    end
    check("to_req_cycles", 32'(hi_cycles), 32'd4);
    check("to_rsp_valid", 32'(rsp_valid), 32'd1);
    check("to_rsp_err", 32'(rsp_err), 32'd2);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    step();

    // Ack in the 4th (timeout) cycle wins
    issue(1'b0, 3'b010, 32'h0000_4000, 32'h0);
    step();
    step();
    step();
    check("la_req_still_high", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_ack = 1'b0;
    check("la_rsp_valid", 32'(rsp_valid), 32'd1);
    check("la_rsp_err", 32'(rsp_err), 32'd0);
    check("la_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    step();

    // Reset mid-MEM with ack pending
    issue(1'b0, 3'b010, 32'h0000_6000, 32'h0);
    check("rm_req_before", 32'(mem_req), 32'd1);
    mem_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_req_async", 32'(mem_req), 32'd0);
    check("rm_rsp_async", 32'(rsp_valid), 32'd0);
    step();
    mem_ack = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("rm_no_rsp_1", 32'(rsp_valid), 32'd0);
    check("rm_ready", 32'(req_ready), 32'd1);
    step();
    check("rm_no_rsp_2", 32'(rsp_valid), 32'd0);

    // Word load after reset
    issue(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    check("pw_mem_addr", mem_addr, 32'h0);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    check("pw_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pw_rsp_rdata", rsp_rdata, 32'h1234_5678);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the CPU datapath. It takes the ALU result as an effective address, plus the store operand and memory-op code. It runs one data-memory transaction over a word-wide req/ack bus and returns a sign- or zero-extended load value or a store completion. Misaligned accesses and memory timeouts are reported as errors instead of reaching memory.

## Interface
Parameters:
- MEM_TIMEOUT, 255: max cycles mem_req stays high without mem_ack before abort; must be 2..65535.

Ports:
- Clock/reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  async active-low reset
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  LSU can accept (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_memop  in  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; others illegal
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  2  00 ok, 01 misaligned/illegal op, 10 timeout
- mem_req  out  1  memory request, held until ack or abort
- mem_we  out  1  write enable
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_wmask  out  4  byte enables; 0000 on reads
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory done; mem_rdata valid same cycle
- mem_rdata  in  32  read word

## Operation
- States: IDLE, MEM, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch we/memop/addr/wdata and check legality.
  - Illegal memop, half with addr[0]=1, or word with addr[1:0]≠00 → RESP with err=01; memory is never touched.
  - Otherwise → MEM and clear the timeout counter.
- MEM:
  - mem_* driven from latched fields and held stable every cycle until leaving MEM.
  - Counter increments each cycle without ack.
  - On mem_ack → RESP with err=00; loads capture the extracted data.
  - Else if counter = MEM_TIMEOUT−1 → RESP with err=10.
  - If ack arrives in the timeout cycle, ack wins.
- RESP: rsp_valid=1 for exactly one cycle with registered rdata/err, then → IDLE.
- Store lanes, with o = addr[1:0]:
  - byte: wdata[7:0] replicated ×4, mask 0001<<o.
  - half: wdata[15:0] replicated ×2, mask 0011<<o.
  - word: wdata as-is, mask 1111.
- Load extract: shift mem_rdata right by 8·o, take low 8/16/32 bits. Sign-extend for 000/001; zero-extend for 100/101.
- mem_addr low two bits are always 00.

## Timing
- Accept at edge N; mem_req high from N+1. Ack at N+1 gives rsp_valid at N+2 (minimum latency 2). Error path: rsp_valid at N+1.
- Timeout: mem_req high for exactly MEM_TIMEOUT cycles, then rsp_valid the next cycle with err=10.
- No new request is accepted until the cycle after rsp_valid; no back-pressure on rsp.
- mem_ack outside MEM is ignored.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=00, mem_req=0, mem_we=0, mem_addr=0, mem_wmask=0, mem_wdata=0.
- Reset mid-transaction: mem_req drops asynchronously, the transaction is abandoned, and no response is issued.
- All outputs are registered except req_ready, which is decoded from state.

## Structure
- Package lsu_pkg holds:
  - memop encodings (MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU)
  - state enum
  - error codes (ERR_NONE, ERR_ALIGN, ERR_TIMEOUT)
- Sub-module lsu_align (combinational) performs the legality check, store mask/replication, and load extraction/extension. The lsu top holds the FSM, counter and registers.

## Test plan
- Store byte: addr 0x1003, wdata 0xAABBCC5A, memop 000, ack at first cycle → mem_addr 0x1000, wmask 1000, wdata 0x5A5A5A5A; rsp_valid 2 cycles after accept, err 00.
- Signed/unsigned half load: addr 0x2002, mem_rdata 0x80F01234. Memop 001 → rdata 0xFFFF80F0; memop 101 → 0x000080F0.
- Misaligned word: addr 0x3001, memop 010 → mem_req never asserts; rsp_valid next cycle, err 01, rdata 0. Memop 011 at aligned address → same result.
- Timeout with MEM_TIMEOUT=4, no ack → mem_req high exactly 4 cycles, rsp err 10. Ack in 4th cycle → err 00.
- Reset during MEM with ack pending → mem_req 0 immediately, no rsp_valid. After reset, a word load to 0x0 with mem_rdata 0x12345678 returns 0x12345678.
